// File: rtl/vga_scan_timer.sv
// 640x480@60 VGA scan timer: sync pulses, scan counters and 1/SCALE coordinates.
// Define VGA_SCAN_FRAME_TICK_EN to add the frame_tick output (one pulse at start of vblank).
module vga_scan_timer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SCALE    = 10
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [5:0] pixel_x_10,
    output logic [5:0] pixel_y_10
`ifdef VGA_SCAN_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SUB_W-1:0] SCALE_LAST = SUB_W'(SCALE - 1);
    localparam logic [9:0]       H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]       H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]       V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]       HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0]       HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]       VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]       VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic [SUB_W-1:0] r_sx;
    logic [SUB_W-1:0] r_sy;
    logic [5:0]       r_x10;
    logic [5:0]       r_y10;

    logic             w_tick;
    logic             w_line_wrap;
    logic [DIV_W-1:0] w_div_next;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic [SUB_W-1:0] w_sx_next;
    logic [SUB_W-1:0] w_sy_next;
    logic [5:0]       w_x10_next;
    logic [5:0]       w_y10_next;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_video_on_next;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_div_next = w_tick ? '0 : r_div + DIV_W'(1);

    // Scaled coordinates come from sub-counters that step alongside h/v,
    // so no divider is needed; they freeze on the last active pixel/line.
    always_comb begin
        w_h_next    = r_h;
        w_v_next    = r_v;
        w_sx_next   = r_sx;
        w_sy_next   = r_sy;
        w_x10_next  = r_x10;
        w_y10_next  = r_y10;
        w_line_wrap = 1'b0;
        if (w_tick) begin
            if (r_h == H_LAST) begin
                w_h_next    = '0;
                w_sx_next   = '0;
                w_x10_next  = '0;
                w_line_wrap = 1'b1;
                if (r_v == V_LAST) begin
                    w_v_next   = '0;
                    w_sy_next  = '0;
                    w_y10_next = '0;
                end else begin
                    w_v_next = r_v + 10'd1;
                    if (r_v < V_ACT_LAST) begin
                        if (r_sy == SCALE_LAST) begin
                            w_sy_next  = '0;
                            w_y10_next = r_y10 + 6'd1;
                        end else begin
                            w_sy_next = r_sy + SUB_W'(1);
                        end
                    end
                end
            end else begin
                w_h_next = r_h + 10'd1;
                if (r_h < H_ACT_LAST) begin
                    if (r_sx == SCALE_LAST) begin
                        w_sx_next  = '0;
                        w_x10_next = r_x10 + 6'd1;
                    end else begin
                        w_sx_next = r_sx + SUB_W'(1);
                    end
                end
            end
        end
    end

    assign w_hsync_next    = ~((w_h_next >= HS_START) && (w_h_next < HS_END));
    assign w_vsync_next    = ~((w_v_next >= VS_START) && (w_v_next < VS_END));
    assign w_video_on_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
            r_x10 <= '0;
            r_y10 <= '0;
        end else begin
            r_div <= w_div_next;
            r_h   <= w_h_next;
            r_v   <= w_v_next;
            r_sx  <= w_sx_next;
            r_sy  <= w_sy_next;
            r_x10 <= w_x10_next;
            r_y10 <= w_y10_next;
        end
    end

    // Outputs load the same next-state values as the counters, keeping one epoch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_tick <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            pixel_x_10 <= '0;
            pixel_y_10 <= '0;
        end else begin
            pixel_tick <= w_tick;
            hsync      <= w_hsync_next;
            vsync      <= w_vsync_next;
            video_on   <= w_video_on_next;
            pixel_x    <= w_h_next;
            pixel_y    <= w_v_next;
            pixel_x_10 <= w_x10_next;
            pixel_y_10 <= w_y10_next;
        end
    end

`ifdef VGA_SCAN_FRAME_TICK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_line_wrap && (r_v == V_ACT_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_vga_scan_timer.sv
// Scoreboard bench for vga_scan_timer with a shortened vertical frame (26 lines).
module tb_vga_scan_timer;

    localparam int V_ACT_TB = 20;
    localparam int H_TOT    = 800;
    localparam int V_TOT    = 26;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic [5:0] x10;
        logic [5:0] y10;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       pixel_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [5:0] pixel_x_10;
    logic [5:0] pixel_y_10;
`ifdef VGA_SCAN_FRAME_TICK_EN
    logic       frame_tick;
    int         ft_count = 0;
`endif

    vga_scan_timer #(
        .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_ACTIVE(V_ACT_TB), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(2), .SCALE(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pixel_tick(pixel_tick),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .pixel_x_10(pixel_x_10),
        .pixel_y_10(pixel_y_10)
`ifdef VGA_SCAN_FRAME_TICK_EN
        ,
        .frame_tick(frame_tick)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last_exp;
    logic rst_q = 1'b1;
    logic prev_tick = 1'b0;
    int   cyc = 0;
    int   t_first = -1;
    int   frame_len_seen = 0;
    int   hs_low_clks = 0;
    int   vs_low_clks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rst_q <= reset;
        cyc   <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Hand-derived timing: hsync low 656..751, vsync low lines 22..23,
    // visible x<640 / y<20, scaled y holds at 1 after line 19.
    function automatic exp_t expect_at(input int n);
        exp_t e;
        int x, y;
        x = n % H_TOT;
        y = (n / H_TOT) % V_TOT;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.hs  = !(x >= 656 && x < 752);
        e.vs  = !(y >= 22 && y < 24);
        e.von = (x < 640) && (y < 20);
        e.x10 = (x < 640) ? 6'(x / 10) : 6'd63;
        e.y10 = (y < 20) ? 6'(y / 10) : 6'd1;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = {pixel_x, pixel_y, hsync, vsync, video_on, pixel_x_10, pixel_y_10};
        return a;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            chk("reset_state", 64'({pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, pixel_x_10, pixel_y_10}),
                64'({1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 6'd0, 6'd0}));
`ifdef VGA_SCAN_FRAME_TICK_EN
            chk("reset_frame_tick", 64'(frame_tick), 64'(0));
`endif
            last_exp  = expect_at(0);
            prev_tick = 1'b0;
            t_first   = -1;
        end else begin
            if (pixel_tick) begin
                chk("tick_spacing", 64'(prev_tick), 64'(0));
                if (q.size() == 0) begin
                    chk("unexpected_tick", 64'(actual()), 64'(last_exp));
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: pixel tick with no expected entry (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("pixel", 64'(actual()), 64'(e));
                    last_exp = e;
                    if (e.x == 10'd1 && e.y == 10'd0) begin
                        if (t_first >= 0) begin
                            chk("frame_len_clks", 64'(cyc - t_first), 64'(41600));
                            frame_len_seen++;
                        end
                        t_first = cyc;
                    end
                end
            end else begin
                chk("hold", 64'(actual()), 64'(last_exp));
            end
            prev_tick = pixel_tick;
            if (!hsync) hs_low_clks++;
            if (!vsync) vs_low_clks++;
`ifdef VGA_SCAN_FRAME_TICK_EN
            if (frame_tick) begin
                ft_count++;
                chk("frame_tick_pos", 64'({pixel_tick, pixel_y, pixel_x}), 64'({1'b1, 10'd20, 10'd0}));
            end
`endif
        end
    end

    task automatic drain();
        int budget;
        budget = q.size() * 2 + 50;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        // Segment 1: run to (300,12), then abort the frame with a 1-clk reset.
        for (int n = 1; n <= 12 * H_TOT + 300; n++) q.push_back(expect_at(n));
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        drain();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        // Segment 2: a whole frame from (0,0) through the wrap to (5,0).
        for (int n = 1; n <= V_TOT * H_TOT + 5; n++) q.push_back(expect_at(n));
        drain();
        chk("frame_len_measured", 64'(frame_len_seen), 64'(1));
        chk("hsync_low_clks", 64'(hs_low_clks), 64'(38 * 192));
        chk("vsync_low_clks", 64'(vs_low_clks), 64'(3200));
`ifdef VGA_SCAN_FRAME_TICK_EN
        chk("frame_tick_count", 64'(ft_count), 64'(1));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
